uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_framer.sv | 99 +++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake plus serial line and frame status of the UART transmitter
interface uart_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic valid_in;
  logic ready_out;
  logic tx;
  logic busy;
  logic frame_done;
  modport master(output data_in, valid_in, input ready_out, tx, busy, frame_done);
  modport slave(input data_in, valid_in, output ready_out, tx, busy, frame_done);
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: one-word holding register feeding a start/data/parity/stop serialiser
module uart_tx_framer #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic reset,
  uart_tx_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_W);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_W - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [NW-1:0] bit_cnt, bit_n;
  logic [DATA_W-1:0] hold, shift, shift_n;
  logic hold_valid, hold_valid_n, par, par_n, tx_q, tx_n, ready_q, unload, bit_end, accept;
  assign accept = bus.valid_in & ready_q;
  assign bit_end = baud == BAUD_LAST;
  assign bus.ready_out = ready_q;
  assign bus.tx = tx_q;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = state == STOP && bit_end && bit_cnt == STOP_LAST;
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    tx_n = tx_q;
    unload = 1'b0;
    case (state)
      IDLE: unload = hold_valid;
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = shift[0];
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        tx_n = shift[1];
        bit_n = bit_cnt == DATA_LAST ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == DATA_LAST) begin
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
          tx_n = (PARITY_EN != 0) ? par : 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n = 1'b1;
      end
      STOP: if (bit_end) begin
        bit_n = bit_cnt == STOP_LAST ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == STOP_LAST) begin
          state_n = IDLE;
          unload = hold_valid;
        end
      end
      default: state_n = IDLE;
    endcase
    // loading the next word overrides whatever the current state decided
    if (unload) begin
      state_n = START;
      shift_n = hold;
      par_n = ^hold ^ (PARITY_ODD != 0);
      tx_n = 1'b0;
      baud_n = '0;
      bit_n = '0;
    end
    hold_valid_n = accept | (hold_valid & ~unload);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      tx_q <= 1'b1;
      ready_q <= 1'b1;
      hold_valid <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      tx_q <= tx_n;
      ready_q <= ~hold_valid_n;
      hold_valid <= hold_valid_n;
    end
  end
  always_ff @(posedge clk) begin
    shift <= shift_n;
    par <= par_n;
    if (accept) hold <= bus.data_in;
  end
endmodule
